status_event_capture: RTL and testbench

STATUS_EVENT_CAPTURE -- requirements
Module: status_event_capture

---
 rtl/status_event_pkg.sv | 22 ++
 rtl/status_event_bit.sv | 69 ++++++
 rtl/status_event_capture.sv | 80 ++++++++
 tb/tb_status_event_capture.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/status_event_pkg.sv
// Shared encodings and width for the status event capture block.
// Edge-mode codes are two bits per input, packed {bit7..bit0} in the top-level parameter.
package status_event_pkg;

    localparam int STATUS_W = 8;

    localparam logic [1:0] EDGE_LEVEL = 2'b00;
    localparam logic [1:0] EDGE_RISE  = 2'b01;
    localparam logic [1:0] EDGE_FALL  = 2'b10;
    localparam logic [1:0] EDGE_BOTH  = 2'b11;

    // Number of set bits in a flag-wide vector (0..8).
    function automatic logic [3:0] count_ones(input logic [STATUS_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < STATUS_W; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/status_event_bit.sv
// One event channel: synchronizer chain, edge history, detector, status flag and
// overflow flag. The drop strobe reports an event lost against an already-set flag.
module status_event_bit
    import status_event_pkg::*;
#(
    parameter logic [1:0] Mode       = EDGE_RISE,
    parameter bit         Sticky     = 1'b1,
    parameter int         SyncStages = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic event_in,
    input  logic clear,
    output logic flag,
    output logic overflow,
    output logic drop
);

    logic [SyncStages-1:0] sync_reg;
    logic                  hist_reg;
    logic                  flag_reg;
    logic                  flag_next;
    logic                  ovf_reg;
    logic                  ovf_next;
    logic                  synced;
    logic                  detect;

    assign synced = sync_reg[SyncStages-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
            flag_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], event_in};
            hist_reg <= synced;
            flag_reg <= flag_next;
            ovf_reg  <= ovf_next;
        end
    end

    always_comb begin
        detect = 1'b0;
        case (Mode)
            EDGE_LEVEL: detect = synced;
            EDGE_RISE:  detect = synced & ~hist_reg;
            EDGE_FALL:  detect = ~synced & hist_reg;
            default:    detect = synced ^ hist_reg;
        endcase
    end

    // A detect coinciding with a clear re-arms the flag and is not counted as lost.
    always_comb begin
        flag_next = detect;
        ovf_next  = 1'b0;
        drop      = 1'b0;
        if (Sticky) begin
            drop      = detect & flag_reg & ~clear;
            flag_next = detect | (flag_reg & ~clear);
            ovf_next  = drop | (ovf_reg & ~clear);
        end
    end

    assign flag     = flag_reg;
    assign overflow = ovf_reg;

endmodule

// File: rtl/status_event_capture.sv
// Multi-bit event capture: per-bit channels feeding a status vector, plus a
// saturating lost-event counter and a registered, maskable interrupt.
module status_event_capture
    import status_event_pkg::*;
#(
    parameter int                    NumInputs  = 8,
    parameter logic [2*STATUS_W-1:0] EdgeMode   = 16'h5555,
    parameter logic [STATUS_W-1:0]   StickyMask = 8'hFF,
    parameter int                    SyncStages = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [STATUS_W-1:0] event_in,
    input  logic                clear_req,
    input  logic [STATUS_W-1:0] clear_mask,
    input  logic [STATUS_W-1:0] int_mask,
    output logic [STATUS_W-1:0] status_out,
    output logic [STATUS_W-1:0] overflow,
    output logic [STATUS_W-1:0] drop_count,
    output logic                interrupt
);

    logic [STATUS_W-1:0] clear_bits;
    logic [STATUS_W-1:0] drop_bits;
    logic [STATUS_W-1:0] drop_count_reg;
    logic [STATUS_W-1:0] drop_count_next;
    logic [STATUS_W:0]   drop_sum;
    logic                clear_all;
    logic                interrupt_reg;

    assign clear_bits = clear_mask & {STATUS_W{clear_req}};
    assign clear_all  = clear_req && (clear_mask == {STATUS_W{1'b1}});

    generate
        for (genvar gi = 0; gi < STATUS_W; gi++) begin : g_bit
            if (gi < NumInputs) begin : g_active
                status_event_bit #(
                    .Mode       (EdgeMode[2*gi +: 2]),
                    .Sticky     (StickyMask[gi]),
                    .SyncStages (SyncStages)
                ) u_bit (
                    .clock    (clock),
                    .reset_n  (reset_n),
                    .event_in (event_in[gi]),
                    .clear    (clear_bits[gi]),
                    .flag     (status_out[gi]),
                    .overflow (overflow[gi]),
                    .drop     (drop_bits[gi])
                );
            end else begin : g_unused
                assign status_out[gi] = 1'b0;
                assign overflow[gi]   = 1'b0;
                assign drop_bits[gi]  = 1'b0;
            end
        end
    endgenerate

    // One spare bit in the sum catches the carry that triggers saturation.
    always_comb begin
        drop_sum        = {1'b0, drop_count_reg} + {{(STATUS_W-3){1'b0}}, count_ones(drop_bits)};
        drop_count_next = drop_sum[STATUS_W] ? {STATUS_W{1'b1}} : drop_sum[STATUS_W-1:0];
        if (clear_all) begin
            drop_count_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_reg <= '0;
            interrupt_reg  <= 1'b0;
        end else begin
            drop_count_reg <= drop_count_next;
            interrupt_reg  <= |(status_out & int_mask);
        end
    end

    assign drop_count = drop_count_reg;
    assign interrupt  = interrupt_reg;

endmodule

// File: tb/tb_status_event_capture.sv
// Directed bench: a mixed-mode instance (rise bits 0..6, non-sticky level bit 7)
// driven from a vector table, and an all-both-edge instance for saturation.
module tb_status_event_capture;

    logic       clk;
    logic       reset_n;
    logic [7:0] ev_a;
    logic [7:0] ev_b;
    logic       clear_req;
    logic [7:0] clear_mask;
    logic [7:0] int_mask;
    logic [7:0] st_a, ov_a, dc_a;
    logic       irq_a;
    logic [7:0] st_b, ov_b, dc_b;
    logic       irq_b;

    int n_cmp  = 0;
    int n_fail = 0;

    status_event_capture #(
        .NumInputs(8), .EdgeMode(16'h1555), .StickyMask(8'h7F), .SyncStages(2)
    ) u_mix (
        .clock(clk), .reset_n(reset_n), .event_in(ev_a), .clear_req(clear_req),
        .clear_mask(clear_mask), .int_mask(int_mask), .status_out(st_a),
        .overflow(ov_a), .drop_count(dc_a), .interrupt(irq_a)
    );

    status_event_capture #(
        .NumInputs(8), .EdgeMode(16'hFFFF), .StickyMask(8'hFF), .SyncStages(2)
    ) u_both (
        .clock(clk), .reset_n(reset_n), .event_in(ev_b), .clear_req(clear_req),
        .clear_mask(clear_mask), .int_mask(int_mask), .status_out(st_b),
        .overflow(ov_b), .drop_count(dc_b), .interrupt(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ev;
        logic       clr;
        logic [7:0] cmask;
        logic [7:0] imask;
        logic [7:0] st;
        logic [7:0] ov;
        logic [7:0] drop;
        logic       irq;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [7:0] ev, input logic clr, input logic [7:0] cm,
                                input logic [7:0] im, input logic [7:0] st, input logic [7:0] ov,
                                input logic [7:0] dr, input logic irq);
        vec_t v;
        v.ev = ev; v.clr = clr; v.cmask = cm; v.imask = im;
        v.st = st; v.ov = ov; v.drop = dr; v.irq = irq;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %02h, want %02h", name, idx, act, exp);
        end else begin
            $display("ok   %s step %0d: %02h", name, idx, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ev, clr, cmask, imask | status, overflow, drop_count, interrupt (after that edge)
        vecs[0]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h00, 8'h00, 8'd0, 0);
        vecs[1]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h00, 8'h00, 8'd0, 0);
        vecs[2]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd0, 0);
        vecs[3]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd0, 1);
        vecs[4]  = mk(8'h09, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd0, 1);
        vecs[5]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd0, 1);
        vecs[6]  = mk(8'h09, 0, 8'h00, 8'h01, 8'h09, 8'h00, 8'd0, 1);
        vecs[7]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h09, 8'h00, 8'd0, 1);
        vecs[8]  = mk(8'h01, 0, 8'h00, 8'h01, 8'h09, 8'h08, 8'd1, 1);
        vecs[9]  = mk(8'h01, 1, 8'h08, 8'h01, 8'h01, 8'h00, 8'd1, 1);
        vecs[10] = mk(8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd1, 1);
        vecs[11] = mk(8'h21, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd1, 1);
        vecs[12] = mk(8'h01, 0, 8'h00, 8'h01, 8'h01, 8'h00, 8'd1, 1);
        vecs[13] = mk(8'h21, 0, 8'h00, 8'h01, 8'h21, 8'h00, 8'd1, 1);
        vecs[14] = mk(8'h01, 0, 8'h00, 8'h01, 8'h21, 8'h00, 8'd1, 1);
        vecs[15] = mk(8'h01, 1, 8'h20, 8'h01, 8'h21, 8'h00, 8'd1, 1);
        vecs[16] = mk(8'h01, 1, 8'h20, 8'h01, 8'h01, 8'h00, 8'd1, 1);
        vecs[17] = mk(8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h00, 8'd1, 0);
        vecs[18] = mk(8'h01, 1, 8'h01, 8'h01, 8'h00, 8'h00, 8'd1, 1);
        vecs[19] = mk(8'h01, 0, 8'h00, 8'h01, 8'h00, 8'h00, 8'd1, 0);
        vecs[20] = mk(8'h81, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'd1, 0);
        vecs[21] = mk(8'h81, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'd1, 0);
        vecs[22] = mk(8'h81, 0, 8'h00, 8'h80, 8'h80, 8'h00, 8'd1, 0);
        vecs[23] = mk(8'h81, 0, 8'h00, 8'h80, 8'h80, 8'h00, 8'd1, 1);
        vecs[24] = mk(8'h01, 0, 8'h00, 8'h80, 8'h80, 8'h00, 8'd1, 1);
        vecs[25] = mk(8'h01, 0, 8'h00, 8'h80, 8'h80, 8'h00, 8'd1, 1);
        vecs[26] = mk(8'h01, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'd1, 1);
        vecs[27] = mk(8'h01, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'd1, 0);
        vecs[28] = mk(8'h01, 1, 8'hFF, 8'h80, 8'h00, 8'h00, 8'd0, 0);

        reset_n = 1'b0; ev_a = '0; ev_b = '0;
        clear_req = 1'b0; clear_mask = '0; int_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_status", 0, st_a, 8'h00);
        check("reset_overflow", 0, ov_a, 8'h00);
        check("reset_drop", 0, dc_a, 8'h00);
        check("reset_irq", 0, {7'd0, irq_a}, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            ev_a = vecs[i].ev; clear_req = vecs[i].clr;
            clear_mask = vecs[i].cmask; int_mask = vecs[i].imask;
            step();
            check("vec_status", i + 1, st_a, vecs[i].st);
            check("vec_overflow", i + 1, ov_a, vecs[i].ov);
            check("vec_drop", i + 1, dc_a, vecs[i].drop);
            check("vec_irq", i + 1, {7'd0, irq_a}, {7'd0, vecs[i].irq});
        end
        clear_req = 1'b0; clear_mask = '0;

        // Every-cycle toggling on all both-edge sticky bits: 8 drops per clock from edge 4.
        for (int s = 1; s <= 45; s++) begin
            ev_b = (s <= 40 && (s % 2 == 1)) ? 8'hFF : 8'h00;
            step();
            if (s == 3) begin
                check("sat_first_status", s, st_b, 8'hFF);
                check("sat_first_overflow", s, ov_b, 8'h00);
            end
            if (s == 5) check("sat_multi_drop", s, dc_b, 8'd16);
            if (s == 35) check("sat_pre", s, dc_b, 8'd255);
            if (s == 45) check("sat_hold", s, dc_b, 8'hFF);
        end
        check("sat_overflow", 45, ov_b, 8'hFF);
        clear_req = 1'b1; clear_mask = 8'h7F;
        step();
        check("partial_clr_drop", 46, dc_b, 8'hFF);
        check("partial_clr_status", 46, st_b, 8'h80);
        check("partial_clr_ovf", 46, ov_b, 8'h80);
        clear_mask = 8'hFF;
        step();
        check("full_clr_drop", 47, dc_b, 8'h00);
        check("full_clr_status", 47, st_b, 8'h00);
        clear_req = 1'b0; clear_mask = '0;

        // Reset mid-event, then a rising input held high across release.
        ev_a = 8'h00; int_mask = 8'h01;
        repeat (3) step();
        ev_a = 8'h01;
        repeat (3) step();
        check("pre_reset_status", 0, st_a, 8'h01);
        #2;
        reset_n = 1'b0; clear_req = 1'b1; clear_mask = 8'hFF;
        #1;
        check("async_rst_status", 0, st_a, 8'h00);
        check("async_rst_irq", 0, {7'd0, irq_a}, 8'h00);
        repeat (2) step();
        check("in_rst_status", 0, st_a, 8'h00);
        @(negedge clk);
        reset_n = 1'b1; clear_req = 1'b0; clear_mask = '0;
        for (int s = 1; s <= 6; s++) begin
            step();
            check("release_status", s, st_a, (s >= 3) ? 8'h01 : 8'h00);
        end
        check("release_overflow", 6, ov_a, 8'h00);
        check("release_drop", 6, dc_a, 8'h00);
        check("release_irq", 6, {7'd0, irq_a}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
